// File: rtl/aline_scan_sequencer_pkg.sv
// Shared types and defaults for the A-line scan sequencer: state encoding,
// timing defaults and the last-line test used by the frame walker.
package aline_scan_sequencer_pkg;

  localparam int ALINE_WIDTH        = 5;
  localparam int PRI_WIDTH_DEFAULT  = 16;
  localparam int LOAD_LAT_DEFAULT   = 2;
  localparam int TX_TIMEOUT_DEFAULT = 65535;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_FWAIT   = 4'd2,
    S_LOAD    = 4'd3,
    S_FIRE    = 4'd4,
    S_WAIT_TX = 4'd5,
    S_DWELL   = 4'd6,
    S_NEXT    = 4'd7,
    S_DONE    = 4'd8,
    S_FAULT   = 4'd9
  } seq_state_e;

  function automatic logic is_last_aline(input logic [ALINE_WIDTH-1:0] idx,
                                         input logic [ALINE_WIDTH-1:0] num);
    return idx == (num - 1'b1);
  endfunction

endpackage

// File: rtl/aline_scan_sequencer_if.sv
// Control/status bundle between the main FSM, image_configs and the
// transmit FSM on one side and the A-line scan sequencer on the other.
interface aline_scan_sequencer_if #(
  parameter int PRI_WIDTH = 16
);
  logic                 start_scan;
  logic                 abort;
  logic [4:0]           num_alines;
  logic [PRI_WIDTH-1:0] pri_cycles;
  logic                 cfg_busy;
  logic                 transmit_in_progress;
  logic                 transmit_complete;

  logic                 cfg_rd_en;
  logic [4:0]           which_aline;
  logic                 load_delays;
  logic                 start_transmit;
  logic                 next_aline;
  logic                 scan_busy;
  logic                 scan_done;
  logic                 tx_fault;

  modport slave (
    input  start_scan, abort, num_alines, pri_cycles, cfg_busy,
           transmit_in_progress, transmit_complete,
    output cfg_rd_en, which_aline, load_delays, start_transmit,
           next_aline, scan_busy, scan_done, tx_fault
  );

  modport master (
    output start_scan, abort, num_alines, pri_cycles, cfg_busy,
           transmit_in_progress, transmit_complete,
    input  cfg_rd_en, which_aline, load_delays, start_transmit,
           next_aline, scan_busy, scan_done, tx_fault
  );
endinterface

// File: rtl/aline_scan_sequencer_countdown.sv
// Loadable down-counter that parks at zero; one instance times the fetch
// latency, the transmit timeout and the PRI dwell.
module aline_scan_sequencer_countdown #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);
  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/aline_scan_sequencer.sv
// Frame scheduler: walks A-lines 0..N-1 through fetch, load, fire,
// wait-for-complete and PRI dwell, with abort and transmit-timeout handling.
//
//  state   | meaning
//  IDLE    | waiting for an accepted start_scan
//  FETCH   | cfg_rd_en pulse for the current line
//  FWAIT   | waiting LOAD_LAT cycles for delay data
//  LOAD    | load_delays pulse
//  FIRE    | start_transmit pulse
//  WAIT_TX | waiting for transmit_complete or timeout
//  DWELL   | pulse-repetition interval
//  NEXT    | next_aline pulse, advance or finish
//  DONE    | scan_done pulse
//  FAULT   | transmit timed out, tx_fault set
module aline_scan_sequencer
  import aline_scan_sequencer_pkg::*;
#(
  parameter int PRI_WIDTH  = PRI_WIDTH_DEFAULT,
  parameter int LOAD_LAT   = LOAD_LAT_DEFAULT,
  parameter int TX_TIMEOUT = TX_TIMEOUT_DEFAULT
) (
  input logic                   clk,
  input logic                   rst_n,
  aline_scan_sequencer_if.slave bus
);
  localparam int CNT_WIDTH = (PRI_WIDTH > 16) ? PRI_WIDTH : 16;
  localparam logic [CNT_WIDTH-1:0] FWAIT_RELOAD = CNT_WIDTH'(LOAD_LAT - 1);
  localparam logic [CNT_WIDTH-1:0] TX_RELOAD    = CNT_WIDTH'(TX_TIMEOUT - 1);

  seq_state_e state, next_state;

  logic [ALINE_WIDTH-1:0] n_reg;
  logic [ALINE_WIDTH-1:0] which_aline_q;
  logic [PRI_WIDTH-1:0]   pri_reg;
  logic [CNT_WIDTH-1:0]   dwell_reload;
  logic [CNT_WIDTH-1:0]   cnt_value;
  logic                   cnt_load;
  logic                   cnt_zero;
  logic                   accept;

  logic cfg_rd_en_q, load_delays_q, start_transmit_q, next_aline_q;
  logic scan_busy_q, scan_done_q, tx_fault_q;

  // A zero PRI still spends one cycle in DWELL.
  always_comb begin
    dwell_reload = '0;
    if (pri_reg != '0) begin
      dwell_reload = CNT_WIDTH'(pri_reg) - 1'b1;
    end
  end

  aline_scan_sequencer_countdown #(.WIDTH(CNT_WIDTH)) u_countdown (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .value (cnt_value),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    cnt_value  = '0;
    accept     = 1'b0;
    if (state != S_IDLE && bus.abort) begin
      next_state = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start_scan && !bus.cfg_busy) begin
            accept     = 1'b1;
            next_state = (bus.num_alines == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          next_state = S_FWAIT;
          cnt_load   = 1'b1;
          cnt_value  = FWAIT_RELOAD;
        end
        S_FWAIT:  if (cnt_zero) next_state = S_LOAD;
        S_LOAD:   next_state = S_FIRE;
        S_FIRE: begin
          next_state = S_WAIT_TX;
          cnt_load   = 1'b1;
          cnt_value  = TX_RELOAD;
        end
        S_WAIT_TX: begin
          if (bus.transmit_complete) begin
            next_state = S_DWELL;
            cnt_load   = 1'b1;
            cnt_value  = dwell_reload;
          end else if (cnt_zero) begin
            next_state = S_FAULT;
          end
        end
        S_DWELL:  if (cnt_zero) next_state = S_NEXT;
        S_NEXT:   next_state = is_last_aline(which_aline_q, n_reg) ? S_DONE : S_FETCH;
        S_DONE:   next_state = S_IDLE;
        S_FAULT:  next_state = S_IDLE;
        default:  next_state = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from next_state so each is a flop aligned to its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_reg            <= '0;
      pri_reg          <= '0;
      which_aline_q    <= '0;
      cfg_rd_en_q      <= 1'b0;
      load_delays_q    <= 1'b0;
      start_transmit_q <= 1'b0;
      next_aline_q     <= 1'b0;
      scan_busy_q      <= 1'b0;
      scan_done_q      <= 1'b0;
      tx_fault_q       <= 1'b0;
    end else begin
      cfg_rd_en_q      <= (next_state == S_FETCH);
      load_delays_q    <= (next_state == S_LOAD);
      start_transmit_q <= (next_state == S_FIRE);
      next_aline_q     <= (next_state == S_NEXT);
      scan_done_q      <= (next_state == S_DONE);
      scan_busy_q      <= (next_state != S_IDLE);
      if (accept) begin
        n_reg      <= bus.num_alines;
        pri_reg    <= bus.pri_cycles;
        tx_fault_q <= 1'b0;
      end else if (next_state == S_FAULT) begin
        tx_fault_q <= 1'b1;
      end
      if (next_state == S_IDLE || next_state == S_DONE) begin
        which_aline_q <= '0;
      end else if (state == S_NEXT) begin
        which_aline_q <= which_aline_q + 1'b1;
      end
    end
  end

  assign bus.cfg_rd_en      = cfg_rd_en_q;
  assign bus.which_aline    = which_aline_q;
  assign bus.load_delays    = load_delays_q;
  assign bus.start_transmit = start_transmit_q;
  assign bus.next_aline     = next_aline_q;
  assign bus.scan_busy      = scan_busy_q;
  assign bus.scan_done      = scan_done_q;
  assign bus.tx_fault       = tx_fault_q;
endmodule
